// File: rtl/pipeline_hazard_controller_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
// The datapath side (master) supplies decode/execute/memory hazard
// information. The controller side (slave) returns PC select, enables and
// flush strobes.
interface pipeline_hazard_controller_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_jump;
  logic       id_jr;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       mem_branch_taken;
  logic [1:0] pc_sel;
  logic       pc_enable;
  logic       if_id_enable;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, id_jr, ex_mem_read, ex_rt,
           mem_branch_taken,
    input  pc_sel, pc_enable, if_id_enable, if_id_flush, id_ex_flush,
           ex_mem_flush
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, id_jr, ex_mem_read, ex_rt,
           mem_branch_taken,
    output pc_sel, pc_enable, if_id_enable, if_id_flush, id_ex_flush,
           ex_mem_flush
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/PC-select controller for a 5-stage MIPS pipeline.
//
// Priority of actions in any cycle: a taken branch in MEM, then a load-use
// stall, then a j/jal/jr redirect from ID.
//
// Optional macro HAZARD_PERF_COUNTERS_EN builds the saturating stall and
// redirect counters. When the macro is not defined, both counters read 0.
module pipeline_hazard_controller #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_controller_if.slave  hz,
  output logic [CNT_WIDTH-1:0]         stall_count,
  output logic [CNT_WIDTH-1:0]         flush_count
);

  typedef enum logic {RUN, LU_STALL} state_t;

  // Bubbles still owed after the first stall cycle. This value is unused
  // when only a single bubble is configured.
  localparam logic [2:0] BCNT_INIT =
      (LOAD_USE_CYCLES > 1) ? 3'(LOAD_USE_CYCLES - 2) : 3'd0;

  state_t     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       lu;
  logic       stall_ev;
  logic       redirect_ev;
  logic [1:0] pc_sel;
  logic       pc_enable, if_id_enable;
  logic       if_id_flush, id_ex_flush, ex_mem_flush;

  // Load-use hazard: a load in EX writes a register that the ID instruction reads.
  // Register $0 is excluded because it never carries a real dependency.
  assign lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
              ((hz.ex_rt == hz.id_rs) ||
               (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // Compute the next state and the same-cycle control outputs, in priority order.
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    pc_sel       = 2'd0;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    stall_ev     = 1'b0;
    redirect_ev  = 1'b0;
    if (reset) begin
      state_d = RUN;
      bcnt_d  = 3'd0;
    end else if (hz.mem_branch_taken) begin
      // A taken branch squashes everything younger, including any stall in progress.
      pc_sel       = 2'd1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = RUN;
      bcnt_d       = 3'd0;
      redirect_ev  = 1'b1;
    end else if ((state_q == LU_STALL) || lu) begin
      // Hold PC and IF/ID, and send a bubble into EX. Jumps wait because ID is held.
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
      stall_ev     = 1'b1;
      if (state_q == RUN) begin
        if (LOAD_USE_CYCLES > 1) begin
          state_d = LU_STALL;
          bcnt_d  = BCNT_INIT;
        end
      end else if (bcnt_q == 3'd0) begin
        state_d = RUN;
      end else begin
        bcnt_d = bcnt_q - 3'd1;
      end
    end else if (hz.id_jump || hz.id_jr) begin
      pc_sel      = hz.id_jr ? 2'd3 : 2'd2;
      if_id_flush = 1'b1;
      redirect_ev = 1'b1;
    end
  end

  // Register the FSM state and the bubble counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      bcnt_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign hz.pc_sel       = pc_sel;
  assign hz.pc_enable    = pc_enable;
  assign hz.if_id_enable = if_id_enable;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Update the saturating performance counters. They stop at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (redirect_ev && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // Register the performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic unused_events;
  assign unused_events = stall_ev ^ redirect_ev;
  assign stall_count   = '0;
  assign flush_count   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller. Two instances share the
// same stimulus:
//   - A: 1 bubble per load-use hazard, 32-bit counters.
//   - B: 3 bubbles per load-use hazard, 4-bit counters.
// A reference model counts the remaining stall cycles directly.
module tb_pipeline_hazard_controller;

`ifdef HAZARD_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  pc_sel;
    logic        pc_en;
    logic        ifid_en;
    logic        f_ifid;
    logic        f_idex;
    logic        f_exmem;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
  logic id_uses_rt = 1'b0, id_jump = 1'b0, id_jr = 1'b0;
  logic ex_mem_read = 1'b0, mem_branch_taken = 1'b0;

  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   m_left[2];
  longint m_sc[2];
  longint m_fc[2];
  int   n_checks = 0;
  int   n_pass = 0;

  pipeline_hazard_controller_if hz_a ();
  pipeline_hazard_controller_if hz_b ();

  assign hz_a.id_rs = id_rs;            assign hz_b.id_rs = id_rs;
  assign hz_a.id_rt = id_rt;            assign hz_b.id_rt = id_rt;
  assign hz_a.id_uses_rt = id_uses_rt;  assign hz_b.id_uses_rt = id_uses_rt;
  assign hz_a.id_jump = id_jump;        assign hz_b.id_jump = id_jump;
  assign hz_a.id_jr = id_jr;            assign hz_b.id_jr = id_jr;
  assign hz_a.ex_mem_read = ex_mem_read; assign hz_b.ex_mem_read = ex_mem_read;
  assign hz_a.ex_rt = ex_rt;            assign hz_b.ex_rt = ex_rt;
  assign hz_a.mem_branch_taken = mem_branch_taken;
  assign hz_b.mem_branch_taken = mem_branch_taken;

  pipeline_hazard_controller #(.LOAD_USE_CYCLES(1), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(reset), .hz(hz_a.slave),
    .stall_count(sc_a), .flush_count(fc_a)
  );

  pipeline_hazard_controller #(.LOAD_USE_CYCLES(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .hz(hz_b.slave),
    .stall_count(sc_b), .flush_count(fc_b)
  );

  always #5 clk = ~clk;

  // Reference model. This function produces the expected outputs for the
  // current inputs, then advances the model by one clock edge.
  task automatic model_step(input int d, input int luc, input longint maxc,
                            output exp_t e);
    bit lu;
    lu = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e = '0;
    e.pc_en = 1'b1;
    e.ifid_en = 1'b1;
    e.sc = PERF ? 32'(m_sc[d]) : 32'd0;
    e.fc = PERF ? 32'(m_fc[d]) : 32'd0;
    if (reset) begin
      m_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end else if (mem_branch_taken) begin
      e.pc_sel = 2'd1;
      e.f_ifid = 1'b1; e.f_idex = 1'b1; e.f_exmem = 1'b1;
      m_left[d] = 0;
      if (m_fc[d] < maxc) m_fc[d]++;
    end else if (m_left[d] > 0 || lu) begin
      e.pc_en = 1'b0; e.ifid_en = 1'b0; e.f_idex = 1'b1;
      if (m_left[d] > 0) m_left[d]--;
      else m_left[d] = luc - 1;
      if (m_sc[d] < maxc) m_sc[d]++;
    end else if (id_jump || id_jr) begin
      e.pc_sel = id_jr ? 2'd3 : 2'd2;
      e.f_ifid = 1'b1;
      if (m_fc[d] < maxc) m_fc[d]++;
    end
  endtask

  // Apply one cycle of inputs and queue the expected response of each instance.
  task automatic cycle(input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                       input bit jmp, input bit jr, input bit mrd,
                       input logic [4:0] ert, input bit br, input bit rst);
    exp_t ea, eb;
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_jump = jmp; id_jr = jr;
    ex_mem_read = mrd; ex_rt = ert; mem_branch_taken = br; reset = rst;
    model_step(0, 1, 64'hFFFF_FFFF, ea);
    q_a.push_back(ea);
    model_step(1, 3, 64'd15, eb);
    q_b.push_back(eb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(5'd1, 5'd2, 1'b1, 0, 0, 0, 5'd3, 0, 0);
  endtask

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
  endfunction

  // Monitor: on each falling edge, pop the oldest expectation and compare it
  // with what each instance presents.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("ctrl_a", {24'd0, hz_a.pc_sel, hz_a.pc_enable, hz_a.if_id_enable,
                       hz_a.if_id_flush, hz_a.id_ex_flush, hz_a.ex_mem_flush},
            {24'd0, e.pc_sel, e.pc_en, e.ifid_en, e.f_ifid, e.f_idex, e.f_exmem});
      check("stall_count_a", sc_a, e.sc);
      check("flush_count_a", fc_a, e.fc);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("ctrl_b", {24'd0, hz_b.pc_sel, hz_b.pc_enable, hz_b.if_id_enable,
                       hz_b.if_id_flush, hz_b.id_ex_flush, hz_b.ex_mem_flush},
            {24'd0, e.pc_sel, e.pc_en, e.ifid_en, e.f_ifid, e.f_idex, e.f_exmem});
      check("stall_count_b", {28'd0, sc_b}, e.sc);
      check("flush_count_b", {28'd0, fc_b}, e.fc);
    end
  end

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'd5;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end
    // Reset: hold reset for two cycles, then idle.
    cycle(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    cycle(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1);
    idle(2);
    // Load-use on rs, pulsed for one cycle.
    cycle(5'd8, 5'd2, 0, 0, 0, 1, 5'd8, 0, 0);
    idle(4);
    // Load-use on rt with id_uses_rt set.
    cycle(5'd1, 5'd9, 1, 0, 0, 1, 5'd9, 0, 0);
    idle(4);
    // A load into $0 never stalls. An unused rt never stalls.
    cycle(5'd0, 5'd0, 1, 0, 0, 1, 5'd0, 0, 0);
    cycle(5'd1, 5'd5, 0, 0, 0, 1, 5'd5, 0, 0);
    idle(1);
    // Taken branch in the second stall cycle.
    cycle(5'd8, 5'd2, 0, 0, 0, 1, 5'd8, 0, 0);
    cycle(5'd1, 5'd2, 0, 0, 0, 0, 5'd3, 1, 0);
    idle(2);
    // Jump, jump together with jr, and jr alone.
    cycle(5'd1, 5'd2, 0, 1, 0, 0, 5'd3, 0, 0);
    cycle(5'd1, 5'd2, 0, 1, 1, 0, 5'd3, 0, 0);
    cycle(5'd1, 5'd2, 0, 0, 1, 0, 5'd3, 0, 0);
    idle(1);
    // Jump that arrives together with a load-use hazard. ID is held, so the
    // jump stays asserted until the stall ends.
    cycle(5'd8, 5'd2, 0, 1, 0, 1, 5'd8, 0, 0);
    for (int i = 0; i < 3; i++) cycle(5'd8, 5'd2, 0, 1, 0, 0, 5'd3, 0, 0);
    idle(2);
    // Reset asserted in the second stall cycle.
    cycle(5'd8, 5'd2, 0, 0, 0, 1, 5'd8, 0, 0);
    cycle(5'd1, 5'd2, 0, 0, 0, 0, 5'd3, 0, 1);
    idle(3);
    // Hold the hazard for 20 cycles so the 4-bit counter saturates.
    for (int i = 0; i < 20; i++) cycle(5'd9, 5'd2, 0, 0, 0, 1, 5'd9, 0, 0);
    cycle(5'd1, 5'd2, 0, 1, 0, 0, 5'd3, 0, 0);
    idle(3);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(pick_reg(), pick_reg(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), pick_reg(),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
    end
    idle(1);
    @(negedge clk);
    #1;
    n_checks++;
    if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
    else $display("FAIL drain queues_left actual=%0d required=0", q_a.size() + q_b.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
